// File: rtl/vector_alu_pkg.sv
// Shared opcode definitions, opcode classification helpers and the
// writeback payload type used between the ALU writeback block and its buffer.
package vector_alu_pkg;

    typedef enum logic [4:0] {
        OP_FADD     = 5'd0,
        OP_FSUB     = 5'd1,
        OP_FMULT    = 5'd2,
        OP_VADD     = 5'd3,
        OP_VSUB     = 5'd4,
        OP_VMULT    = 5'd5,
        OP_VDOT     = 5'd6,
        OP_VDOTA    = 5'd7,
        OP_VINDX    = 5'd8,
        OP_VREDUCE  = 5'd9,
        OP_VSPLAT   = 5'd10,
        OP_VSWIZZLE = 5'd11,
        OP_VSADD    = 5'd12,
        OP_VSSUB    = 5'd13,
        OP_VSMULT   = 5'd14,
        OP_VSMA     = 5'd15,
        OP_VCOMPSEL = 5'd16,
        OP_VMAX     = 5'd17,
        OP_VMIN     = 5'd18
    } alu_op_e;

    localparam int VEC_W    = 128;
    localparam int SCALAR_W = 32;

    // Data half of a writeback entry; the destination index is added by the
    // user because its width is a parameter of the writeback block.
    typedef struct packed {
        logic                is_vec;
        logic [VEC_W-1:0]    vdata;
        logic [SCALAR_W-1:0] rdata;
    } wb_entry_t;

    // Vsma and every opcode beyond the defined range produce no writeback.
    function automatic logic op_writes(input logic [4:0] op);
        return (op <= OP_VMIN) && (op != OP_VSMA);
    endfunction

    function automatic logic op_is_vec(input logic [4:0] op);
        logic v;
        v = 1'b0;
        case (op)
            OP_VADD, OP_VSUB, OP_VMULT, OP_VSPLAT, OP_VSWIZZLE, OP_VSADD,
            OP_VSSUB, OP_VSMULT, OP_VCOMPSEL, OP_VMAX, OP_VMIN: v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding retired ALU results until the register file
// takes them. Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo import vector_alu_pkg::*; #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (PW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/vector_alu_wb.sv
// Tracks ops through the fixed-latency vector ALU with a tag shift register,
// captures each result as it emerges and hands it to the register file via
// a buffered valid/ready port, stalling the ALU when a result cannot retire.
module vector_alu_wb import vector_alu_pkg::*; #(
    parameter int LATENCY    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REG_IDX_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_op,
    input  logic [REG_IDX_W-1:0] issue_dst,
    output logic                 issue_ready,
    output logic                 alu_en,
    input  logic [127:0]         vout,
    input  logic [31:0]          rout,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic                 wb_is_vec,
    output logic [REG_IDX_W-1:0] wb_dst,
    output logic [127:0]         wb_vdata,
    output logic [31:0]          wb_rdata,
    output logic                 busy
);

    typedef struct packed {
        logic                 valid;
        logic                 is_vec;
        logic                 wr;
        logic [REG_IDX_W-1:0] dst;
    } tag_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        wb_entry_t            data;
    } wb_slot_t;

    tag_t                      tags [1:LATENCY];
    tag_t                      tag_in;
    tag_t                      tag_ret;
    wb_slot_t                  slot_in;
    wb_slot_t                  head;
    logic                      retire_wr;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      in_flight;

    // Tag for the op entering the ALU this cycle (invalid when nothing issues).
    always_comb begin
        tag_in = '0;
        if (issue_valid && alu_en) begin
            tag_in.valid  = 1'b1;
            tag_in.is_vec = op_is_vec(issue_op);
            tag_in.wr     = op_writes(issue_op);
            tag_in.dst    = issue_dst;
        end
    end

    // Tag shift register advancing in lockstep with the ALU pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= LATENCY; k++) tags[k] <= '0;
        end else if (alu_en) begin
            tags[1] <= tag_in;
            for (int unsigned k = 2; k <= LATENCY; k++) tags[k] <= tags[k-1];
        end
    end

    assign tag_ret   = tags[LATENCY];
    assign retire_wr = tag_ret.valid && tag_ret.wr;

    // A retiring result may only be held back when the buffer cannot drain this cycle.
    assign alu_en      = !(retire_wr && fifo_full && !wb_ready);
    assign issue_ready = alu_en;
    assign push        = retire_wr && alu_en;
    assign pop         = wb_valid && wb_ready;

    // Capture the emerging result, zeroing the field this op does not write.
    always_comb begin
        slot_in             = '0;
        slot_in.dst         = tag_ret.dst;
        slot_in.data.is_vec = tag_ret.is_vec;
        if (tag_ret.is_vec) slot_in.data.vdata = vout;
        else                slot_in.data.rdata = rout;
    end

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (wb_slot_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (slot_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Any valid tag means a result is still owed to the register file.
    always_comb begin
        in_flight = 1'b0;
        for (int unsigned k = 1; k <= LATENCY; k++) in_flight = in_flight | tags[k].valid;
    end

    assign busy     = in_flight || (fifo_count != '0);
    assign wb_valid = !fifo_empty;

    // Head fields are forced to zero while the buffer is empty.
    always_comb begin
        wb_is_vec = 1'b0;
        wb_dst    = '0;
        wb_vdata  = '0;
        wb_rdata  = '0;
        if (wb_valid) begin
            wb_is_vec = head.data.is_vec;
            wb_dst    = head.dst;
            wb_vdata  = head.data.vdata;
            wb_rdata  = head.data.rdata;
        end
    end

endmodule

// File: tb/tb_vector_alu_wb.sv
// Self-checking bench for vector_alu_wb: a queue-based reference model of
// in-flight ops and buffered writebacks, plus directed literal checks.
module tb_vector_alu_wb;

    localparam int LATENCY    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int REG_IDX_W  = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic [4:0]           issue_op;
    logic [REG_IDX_W-1:0] issue_dst;
    logic                 issue_ready;
    logic                 alu_en;
    logic [127:0]         vout;
    logic [31:0]          rout;
    logic                 wb_valid;
    logic                 wb_ready;
    logic                 wb_is_vec;
    logic [REG_IDX_W-1:0] wb_dst;
    logic [127:0]         wb_vdata;
    logic [31:0]          wb_rdata;
    logic                 busy;

    always #5 clk = ~clk;

    vector_alu_wb #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .REG_IDX_W  (REG_IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_dst   (issue_dst),
        .issue_ready (issue_ready),
        .alu_en      (alu_en),
        .vout        (vout),
        .rout        (rout),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_is_vec   (wb_is_vec),
        .wb_dst      (wb_dst),
        .wb_vdata    (wb_vdata),
        .wb_rdata    (wb_rdata),
        .busy        (busy)
    );

    typedef struct {
        int op;
        int dst;
        int age;
    } fl_t;

    typedef struct {
        bit           is_vec;
        int           dst;
        logic [127:0] v;
        logic [31:0]  r;
    } ent_t;

    fl_t          inflight[$];
    ent_t         wbq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           cmp_on = 0;
    logic [127:0] vhist[int];
    int           pops = 0;
    int           vec_pops = 0;
    int           last_pop_cyc = -1;

    // 0 = no writeback, 1 = scalar result, 2 = vector result
    function automatic int op_class(input int op);
        case (op)
            0, 1, 2, 6, 7, 8, 9: return 1;
            3, 4, 5, 10, 11, 12, 13, 14, 16, 17, 18: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_en();
        if (inflight.size() > 0 && inflight[0].age == LATENCY && op_class(inflight[0].op) != 0
            && wbq.size() == FIFO_DEPTH && !wb_ready)
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: compare DUT against model, then advance the model at the edge.
    task automatic step();
        bit           en_m, s_rst, s_iv, s_rdy, is_v;
        int           s_op, s_dst, cls;
        logic [127:0] s_v;
        logic [31:0]  s_r;
        fl_t          f;
        vout = {$urandom, $urandom, $urandom, $urandom};
        rout = $urandom;
        #2;
        vhist[cyc] = vout;
        en_m = model_en();
        if (cmp_on) begin
            chk("alu_en", alu_en, en_m);
            chk("issue_ready", issue_ready, en_m);
            chk("wb_valid", wb_valid, wbq.size() > 0);
            chk("busy", busy, (inflight.size() > 0) || (wbq.size() > 0));
            if (wbq.size() > 0) begin
                chk("wb_is_vec", wb_is_vec, wbq[0].is_vec);
                chk("wb_dst", wb_dst, wbq[0].dst);
                chk("wb_vdata", wb_vdata, wbq[0].v);
                chk("wb_rdata", wb_rdata, wbq[0].r);
            end
        end
        if (rst_n && wb_valid && wb_ready) begin
            pops++;
            if (wb_is_vec) vec_pops++;
            last_pop_cyc = cyc;
        end
        s_rst = rst_n; s_iv = issue_valid; s_rdy = wb_ready;
        s_op = int'(issue_op); s_dst = int'(issue_dst); s_v = vout; s_r = rout;
        @(posedge clk);
        cyc++;
        if (!s_rst) begin
            inflight.delete();
            wbq.delete();
        end else begin
            if (wbq.size() > 0 && s_rdy) void'(wbq.pop_front());
            if (en_m) begin
                if (inflight.size() > 0 && inflight[0].age == LATENCY) begin
                    f = inflight.pop_front();
                    cls = op_class(f.op);
                    if (cls != 0) begin
                        checks++;
                        if (wbq.size() >= FIFO_DEPTH) begin
                            errors++;
                            $display("FAIL fifo_push_when_full: size %0d limit %0d", wbq.size(), FIFO_DEPTH);
                        end
                        is_v = (cls == 2);
                        wbq.push_back('{is_v, f.dst, is_v ? s_v : 128'd0, is_v ? 32'd0 : s_r});
                    end
                end
                for (int i = 0; i < inflight.size(); i++) inflight[i].age = inflight[i].age + 1;
                if (s_iv) inflight.push_back('{s_op, s_dst, 1});
            end
        end
        #1;
    endtask

    task automatic issue(input int op, input int dst);
        issue_valid = 1'b1;
        issue_op    = 5'(op);
        issue_dst   = REG_IDX_W'(dst);
        step();
        issue_valid = 1'b0;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        step();
    endtask

    // which: 0 = wb_valid high, 1 = busy low, 2 = alu_en low
    task automatic wait_for(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 && wb_valid) || (which == 1 && !busy) || (which == 2 && !alu_en)) begin
                ok = 1'b1;
                return;
            end
            idle();
        end
        ok = (which == 0 && wb_valid) || (which == 1 && !busy) || (which == 2 && !alu_en);
    endtask

    task automatic drain();
        bit ok;
        wb_ready = 1'b1;
        wait_for(1, 60, ok);
        chk("drain_done", ok, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wb_valid"}, wb_valid, 1'b0);
        chk({tag, "_wb_is_vec"}, wb_is_vec, 1'b0);
        chk({tag, "_wb_dst"}, wb_dst, 0);
        chk({tag, "_wb_vdata"}, wb_vdata, 0);
        chk({tag, "_wb_rdata"}, wb_rdata, 0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_alu_en"}, alu_en, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c0;
        rst_n = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_dst = '0;
        wb_ready = 1'b1; vout = '0; rout = '0;
        repeat (2) step();
        rst_n = 1'b1;
        check_reset_values("reset");
        cmp_on = 1'b1;

        // Single Vadd: result visible nine cycles after issue
        c0 = cyc;
        issue(3, 7);
        wait_for(0, 20, ok);
        chk("vadd_seen", ok, 1'b1);
        chk("vadd_latency", cyc - c0, 9);
        chk("vadd_is_vec", wb_is_vec, 1'b1);
        chk("vadd_dst", wb_dst, 7);
        chk("vadd_vdata", wb_vdata, vhist[c0 + 8]);
        chk("vadd_rdata", wb_rdata, 0);
        drain();

        // Fadd, Vsma, Vdot back to back: two scalar writebacks only
        pops = 0; vec_pops = 0;
        issue(0, 1); issue(15, 2); issue(6, 3);
        wait_for(1, 40, ok);
        chk("b2b_drained", ok, 1'b1);
        chk("b2b_pops", pops, 2);
        chk("b2b_vec_pops", vec_pops, 0);
        chk("b2b_busy_fall", cyc - last_pop_cyc, 1);

        // Six Vmult with the register file stalled
        wb_ready = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 6; i++) issue(5, 10 + i);
        wait_for(2, 30, ok);
        chk("stall_seen", ok, 1'b1);
        chk("stall_cycle", cyc - c0, 12);
        repeat (3) idle();
        chk("stall_held", alu_en, 1'b0);
        chk("model_full", wbq.size(), FIFO_DEPTH);
        pops = 0;
        wb_ready = 1'b1;
        #1;
        chk("release_alu_en", alu_en, 1'b1);
        idle();
        chk("pushpop_model_count", wbq.size(), FIFO_DEPTH);
        wait_for(1, 40, ok);
        chk("stall_drained", ok, 1'b1);
        chk("stall_pops", pops, 6);

        // Reset with three ops in flight
        issue(3, 1); issue(0, 2); issue(5, 3);
        idle(); idle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        check_reset_values("midreset");
        pops = 0;
        repeat (15) idle();
        chk("midreset_no_wb", pops, 0);

        // Undefined opcode: tracked then dropped
        pops = 0;
        c0 = cyc;
        issue(25, 4);
        wait_for(1, 20, ok);
        chk("op25_cleared", ok, 1'b1);
        chk("op25_busy_cycles", cyc - c0, LATENCY + 1);
        chk("op25_no_wb", pops, 0);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_op    = 5'($urandom_range(0, 31));
            issue_dst   = REG_IDX_W'($urandom);
            wb_ready    = ($urandom_range(0, 9) < 5);
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
